// File: rtl/seq_playback_ctrl_pkg.sv
// seq_playback_ctrl_pkg: shared playback states, sizes and symbol-to-LED decode
package seq_playback_ctrl_pkg;
    localparam int DEPTH_DEF = 10;
    localparam int SYM_W_DEF = 2;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, ON, GAP, DONE} play_state_t;
    typedef logic [SYM_W_DEF-1:0] sym_t;
    // sized for symbols up to 4 bits; callers truncate to their LED width
    function automatic logic [15:0] onehot(input logic [3:0] s);
        return 16'(1) << s;
    endfunction
endpackage

// File: rtl/seq_playback_ctrl_if.sv
// seq_playback_ctrl_if: game-FSM / RAM / LED signals of the playback sequencer
interface seq_playback_ctrl_if #(parameter int SYM_W = 2);
    logic               start;
    logic               abort;
    logic [3:0]         seq_len;
    logic [3:0]         mem_addr;
    logic [SYM_W-1:0]   mem_data;
    logic [2**SYM_W-1:0] led;
    logic               busy;
    logic               done;
    logic [3:0]         cur_idx;
    modport master (output start, abort, seq_len, mem_data, input mem_addr, led, busy, done, cur_idx);
    modport slave  (input start, abort, seq_len, mem_data, output mem_addr, led, busy, done, cur_idx);
endinterface

// File: rtl/seq_playback_ctrl_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == CW'(TICK_DIV - 1);
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/seq_playback_ctrl.sv
// seq_playback_ctrl: plays the stored pattern newest-first on one-hot LEDs
module seq_playback_ctrl
    import seq_playback_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int SYM_W     = SYM_W_DEF,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1,
    parameter int TICK_DIV  = 1
) (
    input logic CLOCK_50,
    input logic reset_n,
    seq_playback_ctrl_if.slave bus
);
    localparam int LW = 2**SYM_W;
    localparam int DW = $clog2((ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS) + 1);
    localparam logic [3:0] LAST = 4'(DEPTH - 1);
    play_state_t state_q, state_d;
    logic [3:0] k_q, k_d, len_q, len_d, addr_q, addr_d, len_clamp;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [DW-1:0] dur_q, dur_d;
    logic tick, clr, dur_end;
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .clr(clr), .tick(tick)
    );
    assign len_clamp = ({1'b0, bus.seq_len} > 5'(DEPTH)) ? 4'(DEPTH) : bus.seq_len;
    assign dur_end = tick && dur_q == DW'((state_q == ON ? ON_TICKS : OFF_TICKS) - 1);
    // prescaler and duration counter restart on every state change
    assign clr = state_d != state_q;
    always_comb begin
        state_d = state_q;
        k_d = k_q;
        len_d = len_q;
        sym_d = sym_q;
        if (bus.abort) state_d = IDLE;
        else case (state_q)
            IDLE: if (bus.start) begin
                k_d = '0;
                len_d = len_clamp;
                state_d = bus.seq_len == '0 ? DONE : FETCH;
            end
            FETCH: state_d = WAIT_DATA;
            WAIT_DATA: begin
                sym_d = bus.mem_data;
                state_d = ON;
            end
            ON: state_d = dur_end ? GAP : ON;
            GAP: if (dur_end) begin
                state_d = (k_q + 4'd1 == len_q) ? DONE : FETCH;
                k_d = (k_q + 4'd1 == len_q) ? k_q : k_q + 4'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        addr_d = (state_d == FETCH && state_q != FETCH) ? LAST - k_d : addr_q;
        dur_d = clr ? '0 : dur_q + DW'(tick);
    end
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            k_q <= '0;
            len_q <= '0;
            sym_q <= '0;
            addr_q <= '0;
            dur_q <= '0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            len_q <= len_d;
            sym_q <= sym_d;
            addr_q <= addr_d;
            dur_q <= dur_d;
        end
    assign bus.led = (state_q == ON) ? LW'(onehot(4'(sym_q))) : '0;
    assign bus.busy = state_q != IDLE;
    assign bus.done = state_q == DONE;
    assign bus.mem_addr = addr_q;
    assign bus.cur_idx = k_q;
endmodule

// File: tb/tb_seq_playback_ctrl.sv
// tb_seq_playback_ctrl: directed playback scenarios checked against a trace model
module tb_seq_playback_ctrl;
    logic clk = 0;
    logic rst_n0 = 0, rst_n1 = 0;
    always #5 clk = ~clk;

    seq_playback_ctrl_if #(.SYM_W(2)) b0();
    seq_playback_ctrl_if #(.SYM_W(2)) b1();
    seq_playback_ctrl #(.TICK_DIV(1)) dut0 (.CLOCK_50(clk), .reset_n(rst_n0), .bus(b0));
    seq_playback_ctrl #(.TICK_DIV(4)) dut1 (.CLOCK_50(clk), .reset_n(rst_n1), .bus(b1));

    logic [1:0] ram [16];
    always @(posedge clk) begin
        b0.mem_data <= ram[b0.mem_addr];
        b1.mem_data <= ram[b1.mem_addr];
    end

    typedef struct packed {
        logic [3:0] led;
        logic       busy;
        logic       done;
        logic [3:0] addr;
        logic [3:0] idx;
    } exp_t;

    exp_t tr [2][256];
    int n [2];
    int p [2];
    logic [3:0] idle_addr [2];
    logic [3:0] idle_idx [2];
    logic last_busy [2];
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [3:0] led, input logic busy, input logic done,
                        input logic [3:0] addr, input logic [3:0] idx);
        tr[d][n[d]] = {led, busy, done, addr, idx};
        n[d]++;
    endtask

    // expected per-cycle outputs of a whole playback, from the cycle after start onward
    task automatic load(input int d, input int sl);
        int len, a, dv;
        if (last_busy[d] || p[d] < n[d]) return;
        dv = d == 0 ? 1 : 4;
        len = sl > 10 ? 10 : sl;
        n[d] = 0;
        p[d] = 0;
        for (int i = 0; i < len; i++) begin
            a = 9 - i;
            repeat (2) push(d, 4'h0, 1'b1, 1'b0, 4'(a), 4'(i));
            repeat (2 * dv) push(d, 4'(1 << ram[a]), 1'b1, 1'b0, 4'(a), 4'(i));
            repeat (dv) push(d, 4'h0, 1'b1, 1'b0, 4'(a), 4'(i));
        end
        if (len > 0) begin
            idle_addr[d] = 4'(10 - len);
            idle_idx[d] = 4'(len - 1);
        end else idle_idx[d] = 4'h0;
        push(d, 4'h0, 1'b1, 1'b1, idle_addr[d], idle_idx[d]);
    endtask

    task automatic mreset(input int d);
        n[d] = 0;
        p[d] = 0;
        idle_addr[d] = 4'h0;
        idle_idx[d] = 4'h0;
        last_busy[d] = 1'b0;
    endtask

    task automatic mabort(input int d);
        n[d] = p[d];
        if (p[d] > 0) begin
            idle_addr[d] = tr[d][p[d]-1].addr;
            idle_idx[d] = tr[d][p[d]-1].idx;
        end
    endtask

    task automatic cmp(input int d, input logic [3:0] led, input logic busy, input logic done,
                       input logic [3:0] addr, input logic [3:0] idx);
        exp_t e;
        e = p[d] < n[d] ? tr[d][p[d]] : {4'h0, 1'b0, 1'b0, idle_addr[d], idle_idx[d]};
        if (p[d] < n[d]) p[d]++;
        last_busy[d] = e.busy;
        chk($sformatf("d%0d led", d), 32'(led), 32'(e.led));
        chk($sformatf("d%0d busy", d), 32'(busy), 32'(e.busy));
        chk($sformatf("d%0d done", d), 32'(done), 32'(e.done));
        chk($sformatf("d%0d mem_addr", d), 32'(addr), 32'(e.addr));
        chk($sformatf("d%0d cur_idx", d), 32'(idx), 32'(e.idx));
    endtask

    always @(negedge clk) begin
        cmp(0, b0.led, b0.busy, b0.done, b0.mem_addr, b0.cur_idx);
        cmp(1, b1.led, b1.busy, b1.done, b1.mem_addr, b1.cur_idx);
    end

    task automatic set_start(input int d, input int sl);
        if (d == 0) begin b0.seq_len = 4'(sl); b0.start = 1'b1; end
        else begin b1.seq_len = 4'(sl); b1.start = 1'b1; end
        load(d, sl);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        b0.start = 0; b1.start = 0;
        b0.abort = 0; b1.abort = 0;
    endtask

    initial begin
        int dn, lit, dark;
        for (int i = 0; i < 16; i++) ram[i] = 2'd0;
        b0.start = 0; b0.abort = 0; b0.seq_len = 0;
        b1.start = 0; b1.abort = 0; b1.seq_len = 0;
        mreset(0);
        mreset(1);
        repeat (3) step();
        chk("reset busy", 32'(b0.busy), 32'd0);
        chk("reset led", 32'(b0.led), 32'd0);
        rst_n0 = 1;
        rst_n1 = 1;
        step();

        // zero-length playback
        set_start(0, 0);
        step();
        chk("len0 done", 32'(b0.done), 32'd1);
        chk("len0 addr", 32'(b0.mem_addr), 32'd0);
        step();
        chk("len0 idle", 32'(b0.busy), 32'd0);

        // single symbol
        ram[9] = 2'd2;
        set_start(0, 1);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) chk("one addr", 32'(b0.mem_addr), 32'd9);
            if (c == 3 || c == 4) chk("one led on", 32'(b0.led), 32'h4);
            if (c == 5) chk("one led gap", 32'(b0.led), 32'h0);
            if (c == 6) chk("one done", 32'(b0.done), 32'd1);
            if (c == 7) chk("one busy off", 32'(b0.busy), 32'd0);
        end

        // three symbols
        ram[8] = 2'd2;
        ram[7] = 2'd0;
        set_start(0, 3);
        dn = 0;
        for (int c = 1; c <= 17; c++) begin
            step();
            dn += int'(b0.done);
            if (c == 6) chk("three addr1", 32'(b0.mem_addr), 32'd8);
            if (c == 8) chk("three led1", 32'(b0.led), 32'h4);
            if (c == 11) chk("three idx2", 32'(b0.cur_idx), 32'd2);
            if (c == 13) chk("three led2", 32'(b0.led), 32'h1);
        end
        chk("three done count", 32'(dn), 32'd1);

        // length clamped to DEPTH
        for (int i = 0; i < 16; i++) ram[i] = 2'(i % 4);
        set_start(0, 12);
        lit = 0;
        for (int c = 1; c <= 52; c++) begin
            step();
            lit += int'(b0.led != 4'h0);
            if (c == 46) chk("clamp last addr", 32'(b0.mem_addr), 32'd0);
            if (c == 51) chk("clamp done", 32'(b0.done), 32'd1);
        end
        chk("clamp lit cycles", 32'(lit), 32'd20);

        // ignored restart while busy, then abort in second ON
        set_start(0, 3);
        dn = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            dn += int'(b0.done);
            if (c == 2) set_start(0, 5);
            if (c == 8) begin
                chk("abort pre led", 32'(b0.led), 32'h1);
                b0.abort = 1'b1;
                mabort(0);
            end
            if (c == 9) begin
                chk("abort led", 32'(b0.led), 32'h0);
                chk("abort busy", 32'(b0.busy), 32'd0);
            end
        end
        chk("abort no done", 32'(dn), 32'd0);
        set_start(0, 1);
        step();
        chk("restart addr", 32'(b0.mem_addr), 32'd9);
        repeat (6) step();

        // slow ticks
        set_start(1, 1);
        lit = 0;
        dark = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            lit += int'(b1.led != 4'h0);
            dark += int'(lit > 0 && b1.led == 4'h0 && b1.busy && !b1.done);
            if (c == 3) chk("div4 led", 32'(b1.led), 32'h2);
            if (c == 15) chk("div4 done", 32'(b1.done), 32'd1);
        end
        chk("div4 lit cycles", 32'(lit), 32'd8);
        chk("div4 dark cycles", 32'(dark), 32'd4);

        // asynchronous reset mid-ON
        set_start(1, 1);
        repeat (4) step();
        chk("pre reset led", 32'(b1.led), 32'h2);
        #2;
        rst_n1 = 0;
        mreset(1);
        #1;
        chk("async rst led", 32'(b1.led), 32'h0);
        chk("async rst busy", 32'(b1.busy), 32'd0);
        repeat (2) step();
        rst_n1 = 1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
